// File: rtl/snake_step_ctrl.sv
// Snake game-step sequencer: owns the 16x8 occupancy bitmap and drives the body FIFO.
// Build option: define WRAP_EN to wrap moves at the field edges instead of ending the game.
module snake_step_ctrl #(
  parameter int MAX_LEN  = 64,
  parameter int INIT_LEN = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  dir,
  input  logic        restart,
  input  logic [3:0]  food_x,
  input  logic [2:0]  food_y,
  output logic        fifo_aclr,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        fifo_rdreq,
  input  logic [7:0]  fifo_q,
  output logic [3:0]  head_x,
  output logic [2:0]  head_y,
  output logic [6:0]  length,
  output logic        food_eaten,
  output logic        game_over,
  output logic        busy,
  input  logic [2:0]  disp_row,
  output logic [15:0] disp_cols
);

  // state | meaning
  // CLR   | clear FIFO, bitmap and length
  // SEED  | push the INIT_LEN seed cells along row 0
  // IDLE  | wait for a move tick
  // STEP  | resolve direction, compute next head
  // CHECK | food match and collision decision
  // POP   | drop tail (or grow)
  // PUSH  | push new head, mark bitmap
  // OVER  | frozen until restart
  typedef enum logic [2:0] {CLR, SEED, IDLE, STEP, CHECK, POP, PUSH, OVER} stateT;

  localparam logic [6:0] MaxLen   = 7'(MAX_LEN);
  localparam logic [3:0] SeedLast = 4'(INIT_LEN - 1);

  stateT state, nextState;

  logic [7:0][15:0] bitMap;
  logic [1:0]  curDir;
  logic [3:0]  headX, nextX;
  logic [2:0]  headY, nextY;
  logic [6:0]  lenReg;
  logic [3:0]  seedCnt;
  logic        edgeExit;
  logic        growReg;

  logic [1:0]  effDir;
  logic [3:0]  stepX;
  logic [2:0]  stepY;
  logic        edgeHit;
  logic        stepExit;
  logic [3:0]  seedX;
  logic [3:0]  tailX;
  logic [2:0]  tailY;
  logic        atFood;
  logic        atTail;
  logic        grow;
  logic        hit;
  logic        unusedQBit;

  assign unusedQBit = fifo_q[3];

  // A request for the exact opposite direction is dropped.
  assign effDir = (dir == {curDir[1], ~curDir[0]}) ? curDir : dir;

  always_comb begin
    stepX   = headX;
    stepY   = headY;
    edgeHit = 1'b0;
    case (effDir)
      2'b00: begin
        stepY   = headY - 3'd1;
        edgeHit = (headY == 3'd0);
      end
      2'b01: begin
        stepY   = headY + 3'd1;
        edgeHit = (headY == 3'd7);
      end
      2'b10: begin
        stepX   = headX - 4'd1;
        edgeHit = (headX == 4'd0);
      end
      default: begin
        stepX   = headX + 4'd1;
        edgeHit = (headX == 4'd15);
      end
    endcase
  end

`ifdef WRAP_EN
  assign stepExit = 1'b0;
`else
  assign stepExit = edgeHit;
`endif

  assign seedX  = SeedLast - seedCnt;
  assign tailX  = fifo_q[7:4];
  assign tailY  = fifo_q[2:0];
  assign atFood = (nextX == food_x) && (nextY == food_y);
  assign grow   = atFood && (lenReg < MaxLen);
  assign atTail = (nextX == tailX) && (nextY == tailY);
  // The tail cell is about to be vacated, so it is only a hit when the snake grows.
  assign hit    = edgeExit || (bitMap[nextY][nextX] && !(atTail && !grow));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= CLR;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      CLR:     nextState = SEED;
      SEED:    if (seedCnt == 4'd0) nextState = IDLE;
      IDLE:    if (tick) nextState = STEP;
      STEP:    nextState = CHECK;
      CHECK:   nextState = hit ? OVER : POP;
      POP:     nextState = PUSH;
      PUSH:    nextState = IDLE;
      OVER:    if (restart) nextState = CLR;
      default: nextState = CLR;
    endcase
  end

  // reset is active-low; while held, CLR must not show on the outputs.
  always_comb begin
    fifo_aclr  = (state == CLR) && reset;
    fifo_wrreq = (state == SEED) || (state == PUSH);
    fifo_rdreq = (state == POP) && !growReg;
    fifo_data  = 8'h00;
    if (state == SEED)      fifo_data = {seedX, 1'b0, 3'd0};
    else if (state == PUSH) fifo_data = {nextX, 1'b0, nextY};
    food_eaten = (state == CHECK) && atFood;
    game_over  = (state == OVER);
    busy       = reset && (state != IDLE) && (state != OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bitMap   <= '0;
      curDir   <= 2'b11;
      headX    <= 4'd0;
      headY    <= 3'd0;
      nextX    <= 4'd0;
      nextY    <= 3'd0;
      lenReg   <= 7'd0;
      seedCnt  <= SeedLast;
      edgeExit <= 1'b0;
      growReg  <= 1'b0;
    end else begin
      case (state)
        CLR: begin
          bitMap  <= '0;
          lenReg  <= 7'd0;
          seedCnt <= SeedLast;
          curDir  <= 2'b11;
          headX   <= 4'd0;
          headY   <= 3'd0;
        end
        SEED: begin
          bitMap[0][seedX] <= 1'b1;
          lenReg           <= lenReg + 7'd1;
          headX            <= seedX;
          headY            <= 3'd0;
          if (seedCnt != 4'd0) seedCnt <= seedCnt - 4'd1;
        end
        STEP: begin
          curDir   <= effDir;
          nextX    <= stepX;
          nextY    <= stepY;
          edgeExit <= stepExit;
        end
        CHECK: growReg <= grow;
        POP: begin
          if (growReg) lenReg <= lenReg + 7'd1;
          else         bitMap[tailY][tailX] <= 1'b0;
        end
        PUSH: begin
          bitMap[nextY][nextX] <= 1'b1;
          headX                <= nextX;
          headY                <= nextY;
        end
        default: ;
      endcase
    end
  end

  assign head_x    = headX;
  assign head_y    = headY;
  assign length    = lenReg;
  assign disp_cols = bitMap[disp_row];

  lenCap: assert property (@(posedge clk) disable iff (!reset) lenReg <= MaxLen);
  mapCount: assert property (@(posedge clk) disable iff (!reset)
    (state == IDLE) |-> ($countones(bitMap) == int'(lenReg)));

endmodule

// File: doc/snake_step_ctrl.md
Name: snake_step_ctrl

Overview:
Game-step sequencer for the snake datapath. It owns the 16x8 occupancy bitmap and drives the external show-ahead body FIFO (head pushed, tail popped), the food match and the collision check. On each move tick it runs one fixed-length step. It feeds the display through a row read port and reports length, food events and game over.

Parameters:
MAX_LEN, 64, maximum body length; at MAX_LEN food is consumed but the snake does not grow (1..127)
INIT_LEN, 3, seeded body length; cells (0,0)..(INIT_LEN-1,0) (1..16)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  single-cycle move strobe from the update prescaler
dir  in  2  requested direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1)
restart  in  1  leaves OVER and re-seeds the body
food_x  in  4  food column
food_y  in  3  food row
fifo_aclr  out  1  body FIFO clear
fifo_wrreq  out  1  push fifo_data
fifo_data  out  8  {head_x, 1'b0, head_y}
fifo_rdreq  out  1  pop tail
fifo_q  in  8  current tail, show-ahead, same packing
head_x  out  4  current head column
head_y  out  3  current head row
length  out  7  body cells occupied
food_eaten  out  1  one-cycle pulse when the head lands on food
game_over  out  1  high in OVER
busy  out  1  high in every state except IDLE and OVER
disp_row  in  3  row select
disp_cols  out  16  combinational bitmap row disp_row; bit n = column n

Behaviour:
- Reset asserted: all outputs 0, bitmap cleared, cur_dir = right (11), state CLR.
- CLR (1 cycle): fifo_aclr=1, bitmap cleared, length=0, then SEED.
- SEED (INIT_LEN cycles, k=0..INIT_LEN-1): fifo_wrreq=1, fifo_data=(k,0), set bit, length++, head=(k,0), then IDLE.
- IDLE: tick seen at edge T goes to STEP. tick is ignored in any other state; no queuing.
- STEP (T+1): latch dir into cur_dir unless it is the exact reverse of cur_dir (up/down, left/right), in which case keep cur_dir. Compute next head; x arithmetic is mod 16, y is mod 8 (see feature). Flag edge-exit.
- CHECK (T+2):
  - grow = (next == food) and (length < MAX_LEN).
  - eat = (next == food); food_eaten pulses here.
  - hit = edge-exit, or bitmap[next] set and not (next == fifo_q and not grow). Moving into the vacating tail cell is legal.
  - hit goes to OVER with no FIFO or bitmap change. Otherwise go to POP.
- POP (T+3): if not grow, fifo_rdreq=1 and clear bitmap[fifo_q]. If grow, no pop and length++.
- PUSH (T+4): fifo_wrreq=1, fifo_data=next, set bitmap[next], head=next, then IDLE.
- Fixed latency: tick at T gives the push at T+4 and busy for 4 cycles. Ticks spaced closer than 5 cycles are dropped.
- OVER: game_over=1, all state frozen, tick ignored. restart goes to CLR. restart in other states is ignored.
- Clear and set in the same cycle never target the same cell, because POP and PUSH are separate states.
- Reset mid-step: immediate return to reset values. No FIFO strobe is left asserted.
- length never exceeds MAX_LEN. bitmap popcount always equals length.

Optional Feature:
WRAP_EN: when defined, edges wrap (x 15 to 0, y 0 to 7, etc.) and edge-exit is never flagged. When undefined, a step leaving the 16x8 field flags edge-exit and the game goes to OVER.

Test Plan:
- Reset released, then wait 1+INIT_LEN cycles -> 3 wrreq pulses with data 0x00, 0x10, 0x20; length=3; head=(2,0); disp_cols[row 0]=0x0007; busy=0.
- tick with dir=11, food at (9,5) -> wrreq at T+4 with 0x30, rdreq at T+3 (fifo_q=0x00); row 0 = 0x000E; length 3.
- Food at (3,0), tick right -> food_eaten pulse at T+2, no rdreq, push 0x30; length=4; row 0 = 0x000F.
- dir=10 (reverse) while moving right -> cur_dir stays right; head advances to x+1.
- Head at (15,0) moving right: WRAP_EN undefined -> game_over at T+3, no wrreq, bitmap unchanged; WRAP_EN defined -> push 0x00 if free.
- Length-5 snake turned into its own body -> OVER. Then restart -> fifo_aclr pulse and re-seed to length 3. A ticked move into the current tail cell without food -> no OVER.
